// File: rtl/tri_oai21_pipe.sv
// Registered valid/ready pipeline that computes a bitwise OAI21, y = ~((a0 | a1) & b0).
// The function is evaluated at the input stage; later stages only move registered results forward.
module tri_oai21_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNTW  = 4
) (
  input  logic             nclk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNTW-1:0]  occ
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [CNTW-1:0]  occ_q, occ_d;
  logic             push, pop;

  // The advance chain runs from the output stage back to the input.
  // Building it through a local variable keeps it a single ordered pass.
  always_comb begin
    logic chain;
    chain          = ~vld_q[DEPTH-1] | out_ready;
    adv            = '0;
    adv[DEPTH-1]   = chain;
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      chain                = ~vld_q[DEPTH-2-i] | chain;
      adv[DEPTH-2-i]       = chain;
    end
  end

  always_comb begin
    vld_d = vld_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      dat_d[k] = dat_q[k];
    end
    if (adv[0]) begin
      vld_d[0] = in_valid;
      dat_d[0] = ~((a0 | a1) & b0);
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (adv[k]) begin
        vld_d[k] = vld_q[k-1];
        dat_d[k] = dat_q[k-1];
      end
    end
  end

  always_comb begin
    push  = in_valid & adv[0];
    pop   = vld_q[DEPTH-1] & out_ready;
    occ_d = occ_q + CNTW'(push) - CNTW'(pop);
  end

  always_ff @(posedge nclk) begin
    if (rst) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_q[DEPTH-1];
  assign y         = dat_q[DEPTH-1];
  assign occ       = occ_q;

endmodule

// File: tb/tb_tri_oai21_pipe.sv
// Directed bench for tri_oai21_pipe: a DEPTH=2 and a DEPTH=4 instance, each with an ordered scoreboard.
module tb_tri_oai21_pipe;

  logic       nclk = 1'b0;
  logic       rst;
  logic [3:0] a0, a1, b0;
  logic       in_valid2, in_ready2, out_valid2, out_ready2;
  logic       in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0] y2, y4;
  logic [3:0] occ2, occ4;

  int n_checks = 0;
  int n_fail   = 0;
  int pushes2  = 0;
  int pops2    = 0;
  logic [3:0] q2[$];
  logic [3:0] q4[$];

  always #5 nclk = ~nclk;

  tri_oai21_pipe #(.WIDTH(4), .DEPTH(2), .CNTW(4)) u2 (
    .nclk(nclk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a0(a0), .a1(a1), .b0(b0), .out_valid(out_valid2), .out_ready(out_ready2),
    .y(y2), .occ(occ2)
  );

  tri_oai21_pipe #(.WIDTH(4), .DEPTH(4), .CNTW(4)) u4 (
    .nclk(nclk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a0(a0), .a1(a1), .b0(b0), .out_valid(out_valid4), .out_ready(out_ready4),
    .y(y4), .occ(occ4)
  );

  // Reference written as the complement of an AOI21 on inverted operands.
  function automatic logic [3:0] oai_ref(input logic [3:0] x0, input logic [3:0] x1, input logic [3:0] c);
    return (~x0 & ~x1) | ~c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: observe transfers at the falling edge, return just after the rising edge.
  logic acc2, acc4;
  task automatic cyc();
    @(negedge nclk);
    acc2 = in_valid2 & in_ready2;
    acc4 = in_valid4 & in_ready4;
    if (!rst) begin
      if (out_valid2 & out_ready2) begin
        pops2++;
        if (q2.size() == 0) check("y2_unexpected_pop", 1, 0);
        else check("y2_order", 32'(y2), 32'(q2.pop_front()));
      end
      if (acc2) begin
        pushes2++;
        q2.push_back(oai_ref(a0, a1, b0));
      end
      if (out_valid4 & out_ready4) begin
        if (q4.size() == 0) check("y4_unexpected_pop", 1, 0);
        else check("y4_order", 32'(y4), 32'(q4.pop_front()));
      end
      if (acc4) q4.push_back(oai_ref(a0, a1, b0));
    end
    @(posedge nclk);
    #1;
  endtask

  // Output stability under stall, and the producer hold rule, for the DEPTH=2 instance.
  logic       p_ov = 1'b0, p_or = 1'b0, p_iv = 1'b0, p_ir = 1'b0, p_rst = 1'b1;
  logic [3:0] p_y = '0, p_a0 = '0, p_a1 = '0, p_b0 = '0;
  always @(negedge nclk) begin
    if (p_ov && !p_or && !p_rst)
      check("y2_hold_stall", {27'd0, out_valid2, y2}, {27'd0, 1'b1, p_y});
    if (p_iv && !p_ir && !p_rst)
      assert (in_valid2 && a0 == p_a0 && a1 == p_a1 && b0 == p_b0)
        else $error("FAIL producer_hold in_valid=%0b", in_valid2);
    p_ov = out_valid2; p_or = out_ready2; p_iv = in_valid2; p_ir = in_ready2;
    p_rst = rst; p_y = y2; p_a0 = a0; p_a1 = a1; p_b0 = b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    int cycles;
    int pops_before;
    logic hold;
    logic [3:0] x1a0, x1a1, x1b0;
    logic [3:0] pa0, pa1, pb0;

    rst = 1'b1;
    in_valid2 = 1'b0; out_ready2 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    a0 = '0; a1 = '0; b0 = '0;
    cyc(); cyc();
    check("rst_out_valid2", 32'(out_valid2), 0);
    check("rst_y2", 32'(y2), 0);
    check("rst_occ2", 32'(occ2), 0);
    check("rst_in_ready2", 32'(in_ready2), 1);
    check("rst_occ4", 32'(occ4), 0);

    // Single push with latency DEPTH-1 after the accept edge.
    rst = 1'b0; out_ready2 = 1'b1;
    a0 = 4'b1010; a1 = 4'b0110; b0 = 4'b1100; in_valid2 = 1'b1;
    #1 check("single_in_ready", 32'(in_ready2), 1);
    cyc();
    in_valid2 = 1'b0;
    check("single_occ_t", 32'(occ2), 1);
    check("single_ov_t", 32'(out_valid2), 0);
    cyc();
    check("single_ov_t1", 32'(out_valid2), 1);
    check("single_y", 32'(y2), 32'(4'b0011));
    check("single_occ_t1", 32'(occ2), 1);
    cyc();
    check("single_occ_end", 32'(occ2), 0);
    check("single_ov_end", 32'(out_valid2), 0);

    // Back-to-back at full throughput.
    pops_before = pops2;
    for (int k = 0; k < 8; k++) begin
      a0 = 4'($urandom); a1 = 4'($urandom); b0 = 4'($urandom); in_valid2 = 1'b1;
      #1 check("b2b_in_ready", 32'(in_ready2), 1);
      cyc();
      check("b2b_occ", 32'(occ2), (k == 0) ? 1 : 2);
      if (k > 0) check("b2b_out_valid", 32'(out_valid2), 1);
    end
    in_valid2 = 1'b0;
    cyc();
    check("b2b_drain_ov", 32'(out_valid2), 1);
    check("b2b_drain_occ", 32'(occ2), 1);
    cyc();
    check("b2b_drain_occ0", 32'(occ2), 0);
    check("b2b_pops", pops2 - pops_before, 8);

    // Backpressure: the third push waits until the first pop frees space.
    out_ready2 = 1'b0;
    a0 = 4'b0001; a1 = 4'b0010; b0 = 4'b1111; in_valid2 = 1'b1;
    x1a0 = a0; x1a1 = a1; x1b0 = b0;
    #1 check("bp_ready1", 32'(in_ready2), 1);
    cyc();
    check("bp_occ1", 32'(occ2), 1);
    a0 = 4'b0100; a1 = 4'b0000; b0 = 4'b0101;
    #1 check("bp_ready2", 32'(in_ready2), 1);
    cyc();
    check("bp_occ2", 32'(occ2), 2);
    a0 = 4'b0000; a1 = 4'b0000; b0 = 4'b1001;
    #1 check("bp_full_ready", 32'(in_ready2), 0);
    cyc();
    check("bp_occ_held", 32'(occ2), 2);
    check("bp_ov_held", 32'(out_valid2), 1);
    check("bp_y_held", 32'(y2), 32'(oai_ref(x1a0, x1a1, x1b0)));
    out_ready2 = 1'b1;
    #1 check("bp_release_ready", 32'(in_ready2), 1);
    cyc();
    in_valid2 = 1'b0;
    check("bp_push_pop_occ", 32'(occ2), 2);
    cyc(); cyc();
    check("bp_drained_occ", 32'(occ2), 0);
    check("bp_queue_empty", q2.size(), 0);

    // Reset with two results in flight.
    out_ready2 = 1'b0;
    a0 = 4'b0011; a1 = 4'b0000; b0 = 4'b0111; in_valid2 = 1'b1;
    cyc();
    a0 = 4'b1000; cyc();
    in_valid2 = 1'b0;
    check("mid_occ2", 32'(occ2), 2);
    rst = 1'b1;
    cyc();
    check("mid_rst_ov", 32'(out_valid2), 0);
    check("mid_rst_y", 32'(y2), 0);
    check("mid_rst_occ", 32'(occ2), 0);
    check("mid_rst_ready", 32'(in_ready2), 1);
    q2.delete();
    rst = 1'b0; out_ready2 = 1'b1;
    repeat (4) cyc();
    check("mid_after_ov", 32'(out_valid2), 0);
    check("mid_after_occ", 32'(occ2), 0);

    // Random vectors with random stalls; the producer holds while not accepted.
    acc_cnt = 0; cycles = 0; hold = 1'b0;
    pops_before = pops2;
    while (acc_cnt < 256 && cycles < 4000) begin
      if (!hold) begin
        a0 = 4'($urandom); a1 = 4'($urandom); b0 = 4'($urandom);
        in_valid2 = ($urandom_range(0, 3) != 0);
      end
      out_ready2 = ($urandom_range(0, 3) != 0);
      cyc();
      cycles++;
      if (acc2) acc_cnt++;
      hold = in_valid2 & ~acc2;
    end
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    cycles = 0;
    while (q2.size() != 0 && cycles < 10) begin
      cyc();
      cycles++;
    end
    check("dual_accepted", acc_cnt, 256);
    check("dual_popped", pops2 - pops_before, 256);
    check("dual_queue_empty", q2.size(), 0);
    check("dual_occ_end", 32'(occ2), 0);

    // Bubble collapse and fill on the DEPTH=4 instance with the consumer stalled.
    out_ready4 = 1'b0;
    a0 = 4'b1100; a1 = 4'b0001; b0 = 4'b1010; in_valid4 = 1'b1;
    pa0 = a0; pa1 = a1; pb0 = b0;
    cyc();
    in_valid4 = 1'b0;
    cyc(); cyc();
    a0 = 4'b0000; a1 = 4'b0010; b0 = 4'b0110; in_valid4 = 1'b1;
    cyc();
    in_valid4 = 1'b0;
    repeat (3) cyc();
    check("bub_occ", 32'(occ4), 2);
    check("bub_ov", 32'(out_valid4), 1);
    check("bub_y", 32'(y4), 32'(oai_ref(pa0, pa1, pb0)));
    check("bub_ready", 32'(in_ready4), 1);
    for (int k = 0; k < 2; k++) begin
      a0 = 4'(k + 5); a1 = 4'(k * 3); b0 = 4'b1110; in_valid4 = 1'b1;
      cycles = 0;
      do begin
        cyc();
        cycles++;
      end while (!acc4 && cycles < 10);
      check("fill_accept", 32'(acc4), 1);
    end
    in_valid4 = 1'b0;
    cyc();
    check("fill_occ", 32'(occ4), 4);
    check("fill_ready", 32'(in_ready4), 0);
    out_ready4 = 1'b1;
    #1 check("fill_release_ready", 32'(in_ready4), 1);
    cycles = 0;
    while (q4.size() != 0 && cycles < 12) begin
      cyc();
      cycles++;
    end
    check("d4_queue_empty", q4.size(), 0);
    check("d4_occ_end", 32'(occ4), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
